// File: rtl/regfile_op_sequencer.sv
// regfile_op_sequencer: five-state micro-op controller that is the sole writer of an 8x8 register file.
// Define REGSEQ_FLAGS_EN to add the zero/carry flag outputs (flag_z, flag_c).
module regfile_op_sequencer #(
    parameter int unsigned DW = 8,
    parameter int unsigned AW = 3,
    parameter int unsigned CW = 16
) (
    input  logic          Clk,
    input  logic          Rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [2:0]    in_op,
    input  logic [AW-1:0] in_rd,
    input  logic [AW-1:0] in_rs,
    input  logic [AW-1:0] in_rt,
    input  logic [DW-1:0] in_imm,
    output logic [AW-1:0] rf_RX,
    output logic [AW-1:0] rf_RY,
    input  logic [DW-1:0] rf_busX,
    input  logic [DW-1:0] rf_busY,
    output logic          rf_WEN,
    output logic [AW-1:0] rf_RW,
    output logic [DW-1:0] rf_busW,
    output logic          done,
    output logic [DW-1:0] result,
    output logic [CW-1:0] retire_cnt
`ifdef REGSEQ_FLAGS_EN
    ,
    output logic          flag_z,
    output logic          flag_c
`endif
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_READ   = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_WB     = 3'd3;
    localparam logic [2:0] S_SETTLE = 3'd4;

    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_SUB  = 3'd1;
    localparam logic [2:0] OP_AND  = 3'd2;
    localparam logic [2:0] OP_OR   = 3'd3;
    localparam logic [2:0] OP_XOR  = 3'd4;
    localparam logic [2:0] OP_LDI  = 3'd5;
    localparam logic [2:0] OP_ADDI = 3'd6;
    localparam logic [2:0] OP_SHL  = 3'd7;

    localparam int unsigned SW = $clog2(DW);
    // With flags the ALU is one bit wider so carry/borrow/shift-out lands in the top bit.
`ifdef REGSEQ_FLAGS_EN
    localparam int unsigned XW = DW + 1;
`else
    localparam int unsigned XW = DW;
`endif

    logic [2:0]    state, state_n;
    logic [2:0]    op_q;
    logic [AW-1:0] rd_q, rs_q, rt_q;
    logic [DW-1:0] imm_q;
    logic [DW-1:0] op_a, op_b;
    logic [DW-1:0] res_q;
    logic [XW-1:0] res_w;
    logic          accept;

    assign in_ready = (state == S_IDLE);
    assign accept   = in_valid & in_ready;
    assign rf_WEN   = (state == S_WB) & ~Rst;
    assign rf_RX    = rs_q;
    assign rf_RY    = rt_q;
    assign rf_RW    = rd_q;
    assign rf_busW  = res_q;

    // State register
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state logic: fixed walk through READ/EXEC/WB/SETTLE after each accept
    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:   if (in_valid) state_n = S_READ;
            S_READ:   state_n = S_EXEC;
            S_EXEC:   state_n = S_WB;
            S_WB:     state_n = S_SETTLE;
            S_SETTLE: state_n = S_IDLE;
            default:  state_n = S_IDLE;
        endcase
    end

    // ALU
    always_comb begin
        res_w = '0;
        case (op_q)
            OP_ADD:  res_w = XW'(op_a) + XW'(op_b);
            OP_SUB:  res_w = XW'(op_a) - XW'(op_b);
            OP_AND:  res_w = XW'(op_a & op_b);
            OP_OR:   res_w = XW'(op_a | op_b);
            OP_XOR:  res_w = XW'(op_a ^ op_b);
            OP_LDI:  res_w = XW'(imm_q);
            OP_ADDI: res_w = XW'(op_a) + XW'(imm_q);
            OP_SHL:  res_w = XW'(op_a) << imm_q[SW-1:0];
            default: res_w = '0;
        endcase
    end

    // Instruction latches, operands, result and retire bookkeeping
    always_ff @(posedge Clk) begin
        if (Rst) begin
            op_q       <= '0;
            rd_q       <= '0;
            rs_q       <= '0;
            rt_q       <= '0;
            imm_q      <= '0;
            op_a       <= '0;
            op_b       <= '0;
            res_q      <= '0;
            result     <= '0;
            retire_cnt <= '0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                op_q  <= in_op;
                rd_q  <= in_rd;
                rs_q  <= in_rs;
                rt_q  <= in_rt;
                imm_q <= in_imm;
            end
            if (state == S_READ) begin
                op_a <= rf_busX;
                op_b <= rf_busY;
            end
            if (state == S_EXEC) begin
                res_q <= res_w[DW-1:0];
            end
            if (state == S_SETTLE) begin
                done       <= 1'b1;
                result     <= res_q;
                retire_cnt <= retire_cnt + CW'(1);
            end
        end
    end

`ifdef REGSEQ_FLAGS_EN
    logic carry_q;

    // Carry captured with the result, published together with it on retire
    always_ff @(posedge Clk) begin
        if (Rst) begin
            carry_q <= 1'b0;
            flag_z  <= 1'b0;
            flag_c  <= 1'b0;
        end else begin
            if (state == S_EXEC) begin
                carry_q <= res_w[XW-1];
            end
            if (state == S_SETTLE) begin
                flag_z <= (res_q == '0);
                flag_c <= carry_q;
            end
        end
    end
`endif

endmodule

// File: tb/tb_regfile_op_sequencer.sv
// Directed bench for regfile_op_sequencer with a register file model that commits writes two edges late.
// Build with REGSEQ_FLAGS_EN defined to also check flag_z/flag_c.
module tb_regfile_op_sequencer;

    localparam int unsigned DW = 8;
    localparam int unsigned AW = 3;
    localparam int unsigned CW = 16;

    logic          Clk = 1'b0;
    logic          Rst;
    logic          in_valid;
    logic          in_ready;
    logic [2:0]    in_op;
    logic [AW-1:0] in_rd, in_rs, in_rt;
    logic [DW-1:0] in_imm;
    logic [AW-1:0] rf_RX, rf_RY, rf_RW;
    logic [DW-1:0] rf_busX, rf_busY, rf_busW;
    logic          rf_WEN;
    logic          done;
    logic [DW-1:0] result;
    logic [CW-1:0] retire_cnt;
`ifdef REGSEQ_FLAGS_EN
    logic          flag_z, flag_c;
`endif

    int checks = 0;
    int errors = 0;

    int            w_cyc, lat, busy, wen_cnt;
    logic [AW-1:0] w_rw;
    logic [DW-1:0] w_bus;

    regfile_op_sequencer #(.DW(DW), .AW(AW), .CW(CW)) dut (
        .Clk(Clk), .Rst(Rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_rd(in_rd), .in_rs(in_rs), .in_rt(in_rt), .in_imm(in_imm),
        .rf_RX(rf_RX), .rf_RY(rf_RY), .rf_busX(rf_busX), .rf_busY(rf_busY),
        .rf_WEN(rf_WEN), .rf_RW(rf_RW), .rf_busW(rf_busW),
        .done(done), .result(result), .retire_cnt(retire_cnt)
`ifdef REGSEQ_FLAGS_EN
        , .flag_z(flag_z), .flag_c(flag_c)
`endif
    );

    always #5 Clk = ~Clk;

    // Register file model: combinational reads, write lands two edges after WEN is sampled
    logic [DW-1:0] rf_mem [8];
    logic          rf_clr;
    logic          p1_v, p2_v;
    logic [AW-1:0] p1_a, p2_a;
    logic [DW-1:0] p1_d, p2_d;

    assign rf_busX = rf_mem[rf_RX];
    assign rf_busY = rf_mem[rf_RY];

    always @(posedge Clk) begin
        if (rf_clr) begin
            for (int i = 0; i < 8; i++) rf_mem[i] <= '0;
            p1_v <= 1'b0;
            p2_v <= 1'b0;
        end else begin
            p1_v <= rf_WEN; p1_a <= rf_RW; p1_d <= rf_busW;
            p2_v <= p1_v;   p2_a <= p1_a;  p2_d <= p1_d;
            if (p2_v) rf_mem[p2_a] <= p2_d;
        end
    end

    // Offer one instruction at a negedge and follow it to its done pulse (ends on that negedge)
    task automatic run_instr(input logic [2:0] op, input logic [AW-1:0] rd, input logic [AW-1:0] rs,
                             input logic [AW-1:0] rt, input logic [DW-1:0] imm);
        in_op = op; in_rd = rd; in_rs = rs; in_rt = rt; in_imm = imm; in_valid = 1'b1;
        w_cyc = 0; lat = 0; busy = 0; wen_cnt = 0; w_rw = '0; w_bus = '0;
        while (!in_ready && w_cyc < 20) begin
            @(negedge Clk);
            w_cyc++;
        end
        if (!in_ready) begin
            checks++; errors++;
            $display("FAIL accept_timeout: in_ready=%0b required 1", in_ready);
            in_valid = 1'b0;
            return;
        end
        @(posedge Clk);
        for (int k = 1; k <= 20; k++) begin
            @(negedge Clk);
            if (k == 1) in_valid = 1'b0;
            if (!in_ready) busy++;
            if (rf_WEN) begin
                wen_cnt++; w_rw = rf_RW; w_bus = rf_busW;
            end
            if (done) begin
                lat = k - 1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        Rst = 1'b1; rf_clr = 1'b1; in_valid = 1'b0;
        in_op = '0; in_rd = '0; in_rs = '0; in_rt = '0; in_imm = '0;
        repeat (3) @(negedge Clk);
        Rst = 1'b0; rf_clr = 1'b0;
        @(negedge Clk);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %0b expected 1", in_ready); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %0b expected 0", done); end
        checks++; if (result !== 8'h00) begin errors++; $display("FAIL reset_result: got %h expected 00", result); end
        checks++; if (retire_cnt !== 16'd0) begin errors++; $display("FAIL reset_retire_cnt: got %0d expected 0", retire_cnt); end
        checks++; if (rf_WEN !== 1'b0) begin errors++; $display("FAIL reset_wen: got %0b expected 0", rf_WEN); end
`ifdef REGSEQ_FLAGS_EN
        checks++; if (flag_z !== 1'b0) begin errors++; $display("FAIL reset_flag_z: got %0b expected 0", flag_z); end
        checks++; if (flag_c !== 1'b0) begin errors++; $display("FAIL reset_flag_c: got %0b expected 0", flag_c); end
`endif
    endtask

    task automatic test_ldi();
        run_instr(3'd5, 3'd3, 3'd0, 3'd0, 8'h5A);
        checks++; if (lat !== 4) begin errors++; $display("FAIL ldi_latency: got %0d expected 4", lat); end
        checks++; if (busy !== 4) begin errors++; $display("FAIL ldi_busy_cycles: got %0d expected 4", busy); end
        checks++; if (wen_cnt !== 1) begin errors++; $display("FAIL ldi_wen_count: got %0d expected 1", wen_cnt); end
        checks++; if (w_rw !== 3'd3) begin errors++; $display("FAIL ldi_rw: got %0d expected 3", w_rw); end
        checks++; if (w_bus !== 8'h5A) begin errors++; $display("FAIL ldi_busw: got %h expected 5a", w_bus); end
        checks++; if (result !== 8'h5A) begin errors++; $display("FAIL ldi_result: got %h expected 5a", result); end
        checks++; if (retire_cnt !== 16'd1) begin errors++; $display("FAIL ldi_retire_cnt: got %0d expected 1", retire_cnt); end
        @(negedge Clk);
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL ldi_done_pulse: got %0b expected 0", done); end
        checks++; if (rf_mem[3] !== 8'h5A) begin errors++; $display("FAIL ldi_r3: got %h expected 5a", rf_mem[3]); end
    endtask

    task automatic test_add_wrap();
        run_instr(3'd5, 3'd1, 3'd0, 3'd0, 8'hF0);
        run_instr(3'd5, 3'd2, 3'd0, 3'd0, 8'h20);
        run_instr(3'd0, 3'd3, 3'd1, 3'd2, 8'h00);
        checks++; if (result !== 8'h10) begin errors++; $display("FAIL add_wrap_result: got %h expected 10", result); end
        checks++; if (retire_cnt !== 16'd4) begin errors++; $display("FAIL add_wrap_retire_cnt: got %0d expected 4", retire_cnt); end
`ifdef REGSEQ_FLAGS_EN
        checks++; if (flag_c !== 1'b1) begin errors++; $display("FAIL add_wrap_flag_c: got %0b expected 1", flag_c); end
        checks++; if (flag_z !== 1'b0) begin errors++; $display("FAIL add_wrap_flag_z: got %0b expected 0", flag_z); end
`endif
    endtask

    task automatic test_back_to_back();
        run_instr(3'd5, 3'd4, 3'd0, 3'd0, 8'h07);
        run_instr(3'd6, 3'd4, 3'd4, 3'd0, 8'h01);
        checks++; if (w_cyc !== 0) begin errors++; $display("FAIL b2b_wait: got %0d expected 0", w_cyc); end
        checks++; if (lat !== 4) begin errors++; $display("FAIL b2b_latency: got %0d expected 4", lat); end
        checks++; if (result !== 8'h08) begin errors++; $display("FAIL b2b_result: got %h expected 08", result); end
        checks++; if (retire_cnt !== 16'd6) begin errors++; $display("FAIL b2b_retire_cnt: got %0d expected 6", retire_cnt); end
    endtask

    task automatic test_sub_xor();
        run_instr(3'd1, 3'd5, 3'd2, 3'd1, 8'h00);
        checks++; if (result !== 8'h30) begin errors++; $display("FAIL sub_result: got %h expected 30", result); end
`ifdef REGSEQ_FLAGS_EN
        checks++; if (flag_c !== 1'b1) begin errors++; $display("FAIL sub_flag_c: got %0b expected 1", flag_c); end
        checks++; if (flag_z !== 1'b0) begin errors++; $display("FAIL sub_flag_z: got %0b expected 0", flag_z); end
`endif
        run_instr(3'd4, 3'd6, 3'd1, 3'd1, 8'h00);
        checks++; if (result !== 8'h00) begin errors++; $display("FAIL xor_result: got %h expected 00", result); end
        checks++; if (retire_cnt !== 16'd8) begin errors++; $display("FAIL xor_retire_cnt: got %0d expected 8", retire_cnt); end
`ifdef REGSEQ_FLAGS_EN
        checks++; if (flag_z !== 1'b1) begin errors++; $display("FAIL xor_flag_z: got %0b expected 1", flag_z); end
        checks++; if (flag_c !== 1'b0) begin errors++; $display("FAIL xor_flag_c: got %0b expected 0", flag_c); end
`endif
    endtask

    task automatic test_hold_valid();
        int acc_n;
        int idx [3];
        acc_n = 0;
        idx[0] = -1; idx[1] = -1; idx[2] = -1;
        in_op = 3'd7; in_rd = 3'd7; in_rs = 3'd1; in_rt = 3'd0; in_imm = 8'h03; in_valid = 1'b1;
        for (int k = 0; k < 15; k++) begin
            if (in_ready) begin
                if (acc_n < 3) idx[acc_n] = k;
                acc_n++;
            end
            @(negedge Clk);
        end
        in_valid = 1'b0;
        checks++; if (acc_n !== 3) begin errors++; $display("FAIL hold_accept_count: got %0d expected 3", acc_n); end
        checks++; if (idx[1] !== 5) begin errors++; $display("FAIL hold_second_accept: got %0d expected 5", idx[1]); end
        checks++; if (idx[2] !== 10) begin errors++; $display("FAIL hold_third_accept: got %0d expected 10", idx[2]); end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL hold_done: got %0b expected 1", done); end
        checks++; if (result !== 8'h80) begin errors++; $display("FAIL shl_result: got %h expected 80", result); end
        checks++; if (retire_cnt !== 16'd11) begin errors++; $display("FAIL hold_retire_cnt: got %0d expected 11", retire_cnt); end
`ifdef REGSEQ_FLAGS_EN
        checks++; if (flag_c !== 1'b1) begin errors++; $display("FAIL shl_flag_c: got %0b expected 1", flag_c); end
        checks++; if (flag_z !== 1'b0) begin errors++; $display("FAIL shl_flag_z: got %0b expected 0", flag_z); end
`endif
    endtask

    task automatic test_reset_mid();
        logic seen_done;
        in_op = 3'd5; in_rd = 3'd0; in_rs = 3'd0; in_rt = 3'd0; in_imm = 8'hFF; in_valid = 1'b1;
        @(posedge Clk);
        @(negedge Clk);
        in_valid = 1'b0;
        repeat (2) @(negedge Clk);
        checks++; if (rf_WEN !== 1'b1) begin errors++; $display("FAIL rstmid_in_wb: got %0b expected 1", rf_WEN); end
        Rst = 1'b1;
        #1;
        checks++; if (rf_WEN !== 1'b0) begin errors++; $display("FAIL rstmid_wen_suppressed: got %0b expected 0", rf_WEN); end
        @(negedge Clk);
        Rst = 1'b0;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rstmid_in_ready: got %0b expected 1", in_ready); end
        checks++; if (retire_cnt !== 16'd0) begin errors++; $display("FAIL rstmid_retire_cnt: got %0d expected 0", retire_cnt); end
        checks++; if (result !== 8'h00) begin errors++; $display("FAIL rstmid_result: got %h expected 00", result); end
        seen_done = done;
        repeat (4) begin
            @(negedge Clk);
            if (done) seen_done = 1'b1;
        end
        checks++; if (seen_done !== 1'b0) begin errors++; $display("FAIL rstmid_done: got %0b expected 0", seen_done); end
        checks++; if (rf_mem[0] !== 8'h00) begin errors++; $display("FAIL rstmid_r0: got %h expected 00", rf_mem[0]); end
    endtask

    initial begin
        test_reset();
        test_ldi();
        test_add_wrap();
        test_back_to_back();
        test_sub_xor();
        test_hold_valid();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_op_sequencer.md
Name: regfile_op_sequencer

Overview:
Multi-cycle micro-op controller that drives the 8x8 register file (2 read ports, 1 write port, WEN).
- Accepts one ALU instruction at a time over a valid/ready handshake.
- Reads source operands through RX/RY and computes an 8-bit result.
- Writes the result back through RW/busW/WEN, then pulses done.
- Sits between the instruction source and the register file; it is the register file's only writer.

Parameters:
- DW, 8, data width; must match register file bus width.
- AW, 3, register index width; must match register file address width.
- CW, 16, width of the retired-instruction counter.

Ports:
- Clk  in  1  clock; all state updates on posedge.
- Rst  in  1  synchronous, active-high reset.
- in_valid  in  1  instruction offered.
- in_ready  out  1  sequencer can accept; high only in IDLE.
- in_op  in  3  opcode.
- in_rd  in  AW  destination register.
- in_rs  in  AW  source register X.
- in_rt  in  AW  source register Y.
- in_imm  in  DW  immediate.
- rf_RX  out  AW  to register file RX.
- rf_RY  out  AW  to register file RY.
- rf_busX  in  DW  from register file busX (combinational read).
- rf_busY  in  DW  from register file busY.
- rf_WEN  out  1  to register file WEN.
- rf_RW  out  AW  to register file RW.
- rf_busW  out  DW  to register file busW.
- done  out  1  one-cycle pulse when an instruction retires.
- result  out  DW  last written value; held until the next retire.
- retire_cnt  out  CW  count of retired instructions.

Behaviour:
- Reset, applied at a sampling edge with Rst=1:
  - state=IDLE, result=0, retire_cnt=0, done=0.
  - Internal operand/opcode/rd latches cleared to 0.
- rf_WEN = (state==WB) & ~Rst. A reset asserted during WB suppresses that write.
- States and transitions:
  - IDLE -> READ when in_valid & in_ready. Latch op/rd/rs/rt/imm on that edge.
  - READ -> EXEC. rf_RX=rs, rf_RY=rt; latch rf_busX/rf_busY into opA/opB at end of cycle.
  - EXEC -> WB. Compute res from opA/opB/imm per opcode; register it.
  - WB -> SETTLE. rf_WEN=1, rf_RW=rd, rf_busW=res.
  - SETTLE -> IDLE. rf_WEN=0; done=1 for this cycle; result<=res; retire_cnt++.
  - Outside READ, rf_RX/rf_RY hold the last latched rs/rt. Outside WB, rf_RW=rd and rf_busW=res (don't-care to the file).
- SETTLE exists because the register file commits a write up to two edges after sampling WEN. The next READ starts no earlier than two edges after the WB edge, so back-to-back dependent instructions (rd == next rs) read the new value.
- Latency: accept edge to done pulse = 4 cycles. Throughput: one instruction per 5 cycles. in_ready=0 in READ/EXEC/WB/SETTLE.
- Opcodes (all arithmetic mod 2^DW, carry/borrow discarded):
  - 0 ADD: rs+rt
  - 1 SUB: rs-rt
  - 2 AND
  - 3 OR
  - 4 XOR
  - 5 LDI: imm
  - 6 ADDI: rs+imm
  - 7 SHL: rs<<imm[2:0], zero-fill
- Register 0 is an ordinary writable register (no hard-wired zero).
- retire_cnt wraps from 2^CW-1 to 0.
- in_valid while busy is ignored; the source must hold it until the in_ready handshake.
- Input changes outside the accept edge have no effect.
- Reset mid-instruction: instruction dropped, no done, retire_cnt unchanged (cleared to 0).

Optional Feature:
- Macro REGSEQ_FLAGS_EN.
- Defined: adds outputs flag_z (1) and flag_c (1), reset to 0.
  - Updated only on the SETTLE cycle edge.
  - flag_z = (res==0).
  - flag_c = carry-out for ADD/ADDI, borrow for SUB (rs<rt unsigned), last bit shifted out for SHL with imm[2:0]!=0, else 0.
- Undefined: ports and logic absent; behaviour otherwise identical.

Test Plan:
- Reset then LDI rd=3 imm=0x5A -> in_ready=0 for 4 cycles; rf_WEN high exactly once with RW=3, busW=0x5A; done 4 cycles after accept; result=0x5A; retire_cnt=1.
- LDI r1=0xF0, LDI r2=0x20, ADD r3=r1+r2 -> r3=0x10 (wrap); with flags: flag_c=1, flag_z=0.
- Back-to-back dependency: LDI r4=0x07 then ADDI r4=r4+0x01 issued at first in_ready -> result=0x08, proving SETTLE spacing.
- SUB r5=r2-r1 (0x20-0xF0) -> 0x30; flags: flag_c=1. XOR r6=r1^r1 -> 0x00; flag_z=1.
- SHL r7=r1<<3 -> 0x80. Hold in_valid high continuously -> instructions accepted every 5 cycles only.
- Assert Rst during WB of LDI r0=0xFF -> rf_WEN stays 0; r0 unchanged; done never pulses; retire_cnt=0; in_ready=1 next cycle.
